q_event_scheduler: RTL and testbench

// Timing-point scheduler that sits between the quantum decoder and the codeword/pulse issue stage.

---
 rtl/q_event_scheduler_if.sv | 38 +++
 rtl/q_event_scheduler.sv | 130 +++++++++++++
 tb/tb_q_event_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/q_event_scheduler_if.sv
// Purpose: decoder -> scheduler -> issue-stage bus for q_event_scheduler.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side; out_valid is a strobe with no ready.
//
// Ports (signals):
//   in_valid, in_ready, in_timing, in_opcode1/2, in_addr1/2   decoded op entering the queue
//   out_valid, out_opcode1/2, out_addr1/2, out_timing         issued op leaving the scheduler
// Modports: master = decoder/issue side (drives in_*), slave = scheduler (drives out_*, in_ready).
interface q_event_scheduler_if #(
  parameter int TW = 20
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_timing;
  logic [6:0]    in_opcode1;
  logic [6:0]    in_opcode2;
  logic [4:0]    in_addr1;
  logic [4:0]    in_addr2;

  logic          out_valid;
  logic [6:0]    out_opcode1;
  logic [6:0]    out_opcode2;
  logic [4:0]    out_addr1;
  logic [4:0]    out_addr2;
  logic [TW-1:0] out_timing;

  modport master (
    output in_valid, in_timing, in_opcode1, in_opcode2, in_addr1, in_addr2,
    input  in_ready,
    input  out_valid, out_opcode1, out_opcode2, out_addr1, out_addr2, out_timing
  );

  modport slave (
    input  in_valid, in_timing, in_opcode1, in_opcode2, in_addr1, in_addr2,
    output in_ready,
    output out_valid, out_opcode1, out_opcode2, out_addr1, out_addr2, out_timing
  );
endinterface

// File: rtl/q_event_scheduler.sv
// Purpose: in-order timing-point queue; releases each op when t_cnt reaches its timing point, flags late ops.
// Latency: op popped in cycle N (slack taken from t_cnt in N) -> out_valid in N+1; a push is poppable next cycle at earliest.
// Backpressure: in_ready = !full (independent of a same-cycle pop); out_valid is a one-cycle strobe, no backpressure.
//
// Ports: clk, rst_n (async active-low); run (advance timer / allow issue); flush (drop queue, clear t_cnt, late_err);
//        bus (q_event_scheduler_if.slave: in_* op input, out_* issued op); t_cnt (timestamp to decoder);
//        late_err (sticky late flag); level (entries held).
// Optional feature: define Q_LATE_DROP_EN to discard late ops instead of issuing them (late_err is set either way).
module q_event_scheduler #(
  parameter int DEPTH    = 16,
  parameter int SLIP_MAX = 3,
  parameter int TW       = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   flush,
  q_event_scheduler_if.slave     bus,
  output logic [TW-1:0]          t_cnt,
  output logic                   late_err,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [TW-1:0] timing;
    logic [6:0]    opcode1;
    logic [6:0]    opcode2;
    logic [4:0]    addr1;
    logic [4:0]    addr2;
  } op_t;

  typedef enum logic [1:0] {IDLE, EMPTY, WAIT, FIRE} state_t;

  state_t        state, state_nxt;
  op_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  op_t           head;
  logic [TW-1:0] slack;
  logic          due, late, push, pop, issue;
  logic [AW:0]   level_nxt;

  assign head         = mem[rd_ptr];
  // Modular slack: top bit set means the head's timing point is still ahead of t_cnt.
  assign slack        = t_cnt - head.timing;
  assign due          = ~slack[TW-1];
  assign late         = due && (slack > TW'(SLIP_MAX));
  assign bus.in_ready = (level != (AW+1)'(DEPTH));

  assign push = bus.in_valid && bus.in_ready && !flush;
  // IDLE covers the first run cycle after a stop, so no pop happens there.
  assign pop  = run && !flush && (state == WAIT || state == FIRE) && (level != '0) && due;

`ifdef Q_LATE_DROP_EN
  assign issue = pop && !late;
`else
  assign issue = pop;
`endif

  assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = run ? EMPTY : IDLE;
    end else if (!run) begin
      state_nxt = IDLE;
    end else if (level_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (pop) begin
      state_nxt = FIRE;
    end else begin
      state_nxt = WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      t_cnt           <= '0;
      late_err        <= 1'b0;
      level           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_opcode1 <= '0;
      bus.out_opcode2 <= '0;
      bus.out_addr1   <= '0;
      bus.out_addr2   <= '0;
      bus.out_timing  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        t_cnt         <= '0;
        late_err      <= 1'b0;
        level         <= '0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        if (run) t_cnt <= t_cnt + 1'b1;
        level <= level_nxt;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (late) late_err <= 1'b1;
        end
        bus.out_valid <= issue;
        if (issue) begin
          bus.out_opcode1 <= head.opcode1;
          bus.out_opcode2 <= head.opcode2;
          bus.out_addr1   <= head.addr1;
          bus.out_addr2   <= head.addr2;
          bus.out_timing  <= head.timing;
        end
      end
    end
  end

  // Queue storage needs no reset: entries are only read once level says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{timing:  bus.in_timing,
                       opcode1: bus.in_opcode1,
                       opcode2: bus.in_opcode2,
                       addr1:   bus.in_addr1,
                       addr2:   bus.in_addr2};
    end
  end
endmodule

// File: tb/tb_q_event_scheduler.sv
`timescale 1ns/1ps
module tb_q_event_scheduler;
  localparam int DEPTH = 16;
  localparam int SLIP  = 3;
  localparam int TW    = 10;
  localparam int MOD   = 1 << TW;
  localparam int HALF  = 1 << (TW - 1);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   run = 1'b0;
  logic                   flush = 1'b0;
  logic [TW-1:0]          t_cnt;
  logic                   late_err;
  logic [$clog2(DEPTH):0] level;

  q_event_scheduler_if #(.TW(TW)) bus ();

  q_event_scheduler #(.DEPTH(DEPTH), .SLIP_MAX(SLIP), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .flush(flush), .bus(bus),
    .t_cnt(t_cnt), .late_err(late_err), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [TW-1:0] timing;
    logic [6:0]    op1;
    logic [6:0]    op2;
    logic [4:0]    a1;
    logic [4:0]    a2;
  } iss_t;

  typedef struct {
    int cyc;
    int t;
    int lvl;
    int late;
    int rdy;
  } st_t;

  iss_t exp_q[$];
  st_t  st_q[$];
  iss_t mq[$];
  int   m_t = 0;
  int   m_late = 0;
  bit   m_prev_run = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_tm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrap(input int x);
    return ((x % MOD) + MOD) % MOD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_t = 0;
    m_late = 0;
    m_prev_run = 1'b0;
  endtask

  // One clock cycle: record what the DUT should show now, drive inputs, advance the reference model.
  task automatic step(input bit r, input bit f, input bit v, input int tm);
    iss_t op;
    iss_t h;
    int   d;
    st_q.push_back('{cyc, m_t, mq.size(), m_late, int'(mq.size() < DEPTH)});
    op.cyc    = 0;
    op.timing = TW'(wrap(tm));
    op.op1    = 7'($urandom_range(0, 127));
    op.op2    = 7'($urandom_range(0, 127));
    op.a1     = 5'($urandom_range(0, 31));
    op.a2     = 5'($urandom_range(0, 31));
    run            = r;
    flush          = f;
    bus.in_valid   = v;
    bus.in_timing  = op.timing;
    bus.in_opcode1 = op.op1;
    bus.in_opcode2 = op.op2;
    bus.in_addr1   = op.a1;
    bus.in_addr2   = op.a2;
    if (f) begin
      mq.delete();
      m_t = 0;
      m_late = 0;
    end else begin
      // The head may leave only if the scheduler has been running since the previous cycle.
      if (r && m_prev_run && mq.size() > 0) begin
        d = wrap(m_t - int'(mq[0].timing));
        if (d < HALF) begin
          h = mq.pop_front();
          if (d > SLIP) m_late = 1;
`ifdef Q_LATE_DROP_EN
          if (d <= SLIP) begin
            h.cyc = cyc + 1;
            exp_q.push_back(h);
          end
`else
          h.cyc = cyc + 1;
          exp_q.push_back(h);
`endif
        end
      end
      if (v && mq.size() < DEPTH + ((r && m_prev_run) ? 0 : 0) && st_q[$].rdy == 1) mq.push_back(op);
      if (r) m_t = wrap(m_t + 1);
    end
    m_prev_run = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT status every cycle and each issue strobe against the scoreboard.
  initial begin
    st_t  s;
    iss_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
        if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
          s = st_q.pop_front();
          check("t_cnt", 32'(t_cnt), 32'(s.t));
          check("level", 32'(level), 32'(s.lvl));
          check("late_err", 32'(late_err), 32'(s.late));
          check("in_ready", 32'(bus.in_ready), 32'(s.rdy));
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_issue: got no out_valid expected timing %0d at cycle %0d", e.timing, e.cyc);
        end
        if (bus.out_valid) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_timing", 32'(bus.out_timing), 32'(e.timing));
            check("out_opcode1", 32'(bus.out_opcode1), 32'(e.op1));
            check("out_opcode2", 32'(bus.out_opcode2), 32'(e.op2));
            check("out_addr1", 32'(bus.out_addr1), 32'(e.a1));
            check("out_addr2", 32'(bus.out_addr2), 32'(e.a2));
          end else begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got out_valid=1 timing %0d expected out_valid=0 (cycle %0d)",
                     bus.out_timing, cyc);
          end
        end
      end
    end
  end

  initial begin
    bit r, f, v, acc;
    int cand, lag;
    bus.in_valid = 1'b0;
    bus.in_timing = '0;
    bus.in_opcode1 = '0;
    bus.in_opcode2 = '0;
    bus.in_addr1 = '0;
    bus.in_addr2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, free-running timer, nothing issued.
    repeat (6) step(1, 0, 0, 0);
    // Single op: timing 10 pushed at t_cnt=2.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 10);
    repeat (12) step(1, 0, 0, 0);
    // Three ops with the same timing point issue back to back.
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 1, 20);
    repeat (25) step(1, 0, 0, 0);
    // Late op: timing 5 pushed at t_cnt=50.
    step(1, 1, 0, 0);
    while (m_t != 50) step(1, 0, 0, 0);
    step(1, 0, 1, 5);
    repeat (4) step(1, 0, 0, 0);
    // Wrap: timing 1 pushed at t_cnt = MOD-3.
    step(1, 1, 0, 0);
    while (m_t != MOD - 3) step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    repeat (8) step(1, 0, 0, 0);
    // Fill while stopped, overfill attempts, then flush with in_valid high.
    step(0, 1, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 100);
    step(1, 1, 1, 100);
    repeat (3) step(1, 0, 0, 0);

    // Randomized traffic with non-decreasing (modular) timing points.
    last_tm = m_t;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 19) != 0);
      f = ($urandom_range(0, 399) == 0);
      v = ($urandom_range(0, 2) != 0);
      lag = wrap(m_t - last_tm);
      if (lag > 100 && lag < HALF) last_tm = wrap(m_t - 20);
      case ($urandom_range(0, 3))
        0: cand = last_tm;
        1: cand = wrap(m_t + int'($urandom_range(0, 25)));
        2: cand = wrap(last_tm + int'($urandom_range(1, 4)));
        default: cand = wrap(m_t - int'($urandom_range(4, 12)));
      endcase
      if (wrap(cand - last_tm) >= HALF - 64) cand = last_tm;
      acc = v && !f && (mq.size() < DEPTH);
      step(r, f, v, cand);
      if (acc) last_tm = cand;
      if (f) last_tm = 0;
    end

    // Asynchronous reset in the middle of traffic.
    repeat (5) step(1, 0, 1, wrap(m_t + 2));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    st_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, wrap(m_t + 3));
    repeat (10) step(1, 0, 0, 0);

    step(1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d issues never seen expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
